// File: rtl/i2c_reg_sequencer.sv
// Register-access sequencer in front of a byte-level I2C master.
// Optional address-NACK retry: define I2C_SEQ_RETRY_EN.
module i2c_reg_sequencer #(
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       busy,
  output logic [2:0] i2c_cmd,
  output logic [7:0] i2c_din,
  output logic       i2c_wr,
  input  logic       i2c_ready,
  input  logic       i2c_done_tick,
  input  logic       i2c_ack,
  input  logic [7:0] i2c_dout
);

  localparam logic [2:0] CMD_START   = 3'b000;
  localparam logic [2:0] CMD_WR      = 3'b001;
  localparam logic [2:0] CMD_RD      = 3'b010;
  localparam logic [2:0] CMD_STOP    = 3'b011;
  localparam logic [2:0] CMD_RESTART = 3'b100;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_ADDR = 2'b01;
  localparam logic [1:0] ERR_DATA = 2'b10;

  if (MAX_RETRY < 0 || MAX_RETRY > 3) begin : g_bad_retry
    $error("MAX_RETRY must be 0..3");
  end

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GAP,
    WAIT,
    RESP
  } state_t;

  state_t     state, state_n;
  logic [2:0] step, step_n;
  logic [1:0] err, err_n;
  logic [7:0] rdata, rdata_n;
  logic       ack_q, ack_n;
  logic       rw_q, rw_n;
  logic [6:0] dev_q, dev_n;
  logic [7:0] reg_q, reg_n;
  logic [7:0] wdata_q, wdata_n;
`ifdef I2C_SEQ_RETRY_EN
  logic [1:0] retry, retry_n;
`endif

  logic [2:0] step_cmd;
  logic [7:0] step_din;
  logic [2:0] stop_step;
  logic       addr_step;
  logic       ack_eff;

  always_comb begin
    step_cmd = CMD_STOP;
    step_din = 8'h00;
    unique case (1'b1)
      step == 3'd0: step_cmd = CMD_START;
      step == 3'd1: begin
        step_cmd = CMD_WR;
        step_din = {dev_q, 1'b0};
      end
      step == 3'd2: begin
        step_cmd = CMD_WR;
        step_din = reg_q;
      end
      !rw_q && step == 3'd3: begin
        step_cmd = CMD_WR;
        step_din = wdata_q;
      end
      rw_q && step == 3'd3: step_cmd = CMD_RESTART;
      rw_q && step == 3'd4: begin
        step_cmd = CMD_WR;
        step_din = {dev_q, 1'b1};
      end
      rw_q && step == 3'd5: begin
        step_cmd = CMD_RD;
        step_din = 8'h01;
      end
      default: step_cmd = CMD_STOP;
    endcase
  end

  assign stop_step = rw_q ? 3'd6 : 3'd4;
  assign addr_step = (step == 3'd1) || (rw_q && step == 3'd4);
  // done_tick and ready may arrive together; use the live ack then
  assign ack_eff   = i2c_done_tick ? i2c_ack : ack_q;

  always_comb begin
    state_n = state;
    step_n  = step;
    err_n   = err;
    rdata_n = rdata;
    ack_n   = ack_q;
    rw_n    = rw_q;
    dev_n   = dev_q;
    reg_n   = reg_q;
    wdata_n = wdata_q;
`ifdef I2C_SEQ_RETRY_EN
    retry_n = retry;
`endif
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          rw_n    = req_rw;
          dev_n   = req_dev;
          reg_n   = req_reg;
          wdata_n = req_wdata;
          step_n  = 3'd0;
          err_n   = ERR_OK;
          rdata_n = 8'h00;
`ifdef I2C_SEQ_RETRY_EN
          retry_n = 2'd0;
`endif
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (i2c_ready) begin
          ack_n   = 1'b0;
          state_n = GAP;
        end
      end
      GAP: state_n = WAIT;
      WAIT: begin
        if (i2c_done_tick) begin
          ack_n = i2c_ack;
          if (step_cmd == CMD_RD) rdata_n = i2c_dout;
        end
        if (i2c_ready) begin
          if (step_cmd == CMD_WR && ack_eff) begin
            err_n   = addr_step ? ERR_ADDR : ERR_DATA;
            step_n  = stop_step;
            state_n = ISSUE;
          end else if (step == stop_step) begin
`ifdef I2C_SEQ_RETRY_EN
            if (err == ERR_ADDR && int'(retry) < MAX_RETRY) begin
              retry_n = retry + 2'd1;
              err_n   = ERR_OK;
              step_n  = 3'd0;
              state_n = ISSUE;
            end else begin
              state_n = RESP;
            end
`else
            state_n = RESP;
`endif
          end else begin
            step_n  = step + 3'd1;
            state_n = ISSUE;
          end
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      step    <= 3'd0;
      err     <= ERR_OK;
      rdata   <= 8'h00;
      ack_q   <= 1'b0;
      rw_q    <= 1'b0;
      dev_q   <= 7'h00;
      reg_q   <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      state   <= state_n;
      step    <= step_n;
      err     <= err_n;
      rdata   <= rdata_n;
      ack_q   <= ack_n;
      rw_q    <= rw_n;
      dev_q   <= dev_n;
      reg_q   <= reg_n;
      wdata_q <= wdata_n;
    end
  end

`ifdef I2C_SEQ_RETRY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retry <= 2'd0;
    else       retry <= retry_n;
  end
`endif

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign i2c_wr    = (state == ISSUE) && i2c_ready;
  assign i2c_cmd   = (state == ISSUE) ? step_cmd : CMD_START;
  assign i2c_din   = (state == ISSUE) ? step_din : 8'h00;
  assign rsp_valid = (state == RESP);
  assign rsp_err   = (state == RESP) ? err : ERR_OK;
  assign rsp_rdata = (state == RESP && err == ERR_OK && rw_q)
                     ? rdata : 8'h00;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Directed bench for i2c_reg_sequencer with a behavioural byte master.
// Expectations follow I2C_SEQ_RETRY_EN when it is defined.
module tb_i2c_reg_sequencer;

  localparam int NRETRY = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [6:0] req_dev = 7'h00;
  logic [7:0] req_reg = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       busy;
  logic [2:0] i2c_cmd;
  logic [7:0] i2c_din;
  logic       i2c_wr;
  logic       m_ready;
  logic       m_done;
  logic       m_ack;
  logic [7:0] m_dout;

  i2c_reg_sequencer #(.MAX_RETRY(NRETRY)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rw(req_rw),
    .req_dev(req_dev),
    .req_reg(req_reg),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .busy(busy),
    .i2c_cmd(i2c_cmd),
    .i2c_din(i2c_din),
    .i2c_wr(i2c_wr),
    .i2c_ready(m_ready),
    .i2c_done_tick(m_done),
    .i2c_ack(m_ack),
    .i2c_dout(m_dout)
  );

  always #5 clk = ~clk;

  int         nack_on = 0;
  logic [7:0] rd_byte = 8'h00;
  int         m_cnt;
  logic [2:0] m_cmd;
  int         wr_n;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ready <= 1'b1;
      m_done  <= 1'b0;
      m_ack   <= 1'b0;
      m_dout  <= 8'h00;
      m_cnt   <= 0;
      m_cmd   <= 3'b000;
      wr_n    <= 0;
    end else begin
      m_done <= 1'b0;
      if (i2c_wr && m_ready) begin
        m_ready <= 1'b0;
        m_cnt   <= 4;
        m_cmd   <= i2c_cmd;
        if (i2c_cmd == 3'b000) wr_n <= 0;
        else if (i2c_cmd == 3'b001) wr_n <= wr_n + 1;
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_ready <= 1'b1;
          if (m_cmd == 3'b001) begin
            m_done <= 1'b1;
            m_ack  <= (wr_n == nack_on);
          end
          if (m_cmd == 3'b010) begin
            m_done <= 1'b1;
            m_ack  <= 1'b1;
            m_dout <= rd_byte;
          end
        end
      end
    end
  end

  logic [2:0] cmd_log [512];
  logic [7:0] din_log [512];
  int         n_log = 0;
  int         n_rsp = 0;
  logic [7:0] r_data = 8'h00;
  logic [1:0] r_err = 2'b00;

  always @(posedge clk) begin
    if (i2c_wr) begin
      cmd_log[n_log] <= i2c_cmd;
      din_log[n_log] <= i2c_din;
      n_log <= n_log + 1;
    end
    if (rsp_valid) begin
      n_rsp  <= n_rsp + 1;
      r_data <= rsp_rdata;
      r_err  <= rsp_err;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic rw, input logic [6:0] dev,
                         input logic [7:0] ra, input logic [7:0] wd);
    int r0;
    bit done;
    r0 = n_rsp;
    done = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_rw    = rw;
    req_dev   = dev;
    req_reg   = ra;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (n_rsp != r0) done = 1;
    end
    if (!done) chk("rsp_timeout", 32'd0, 32'd1);
    repeat (4) @(negedge clk);
    chk("rsp_count", n_rsp - r0, 32'd1);
  endtask

  int attempts;
  int base;
  int nl;
  int nr;
  bit seen;

  initial begin
`ifdef I2C_SEQ_RETRY_EN
    attempts = NRETRY + 1;
`else
    attempts = 1;
`endif
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_i2c_wr", i2c_wr, 0);
    chk("rst_i2c_cmd", i2c_cmd, 0);
    chk("rst_i2c_din", i2c_din, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    nack_on = 0;
    base = n_log;
    run_req(1'b0, 7'h50, 8'h10, 8'hA5);
    chk("wr_slots", n_log - base, 5);
    chk("wr_c0", cmd_log[base], 3'b000);
    chk("wr_c1", cmd_log[base+1], 3'b001);
    chk("wr_d1", din_log[base+1], 8'hA0);
    chk("wr_c2", cmd_log[base+2], 3'b001);
    chk("wr_d2", din_log[base+2], 8'h10);
    chk("wr_c3", cmd_log[base+3], 3'b001);
    chk("wr_d3", din_log[base+3], 8'hA5);
    chk("wr_c4", cmd_log[base+4], 3'b011);
    chk("wr_err", r_err, 2'b00);
    chk("wr_rdata", r_data, 8'h00);

    rd_byte = 8'h3C;
    base = n_log;
    run_req(1'b1, 7'h50, 8'h22, 8'hFF);
    chk("rd_slots", n_log - base, 7);
    chk("rd_c0", cmd_log[base], 3'b000);
    chk("rd_d1", din_log[base+1], 8'hA0);
    chk("rd_d2", din_log[base+2], 8'h22);
    chk("rd_c3", cmd_log[base+3], 3'b100);
    chk("rd_c4", cmd_log[base+4], 3'b001);
    chk("rd_d4", din_log[base+4], 8'hA1);
    chk("rd_c5", cmd_log[base+5], 3'b010);
    chk("rd_d5", din_log[base+5], 8'h01);
    chk("rd_c6", cmd_log[base+6], 3'b011);
    chk("rd_err", r_err, 2'b00);
    chk("rd_rdata", r_data, 8'h3C);

    nack_on = 2;
    base = n_log;
    run_req(1'b0, 7'h50, 8'h33, 8'h5A);
    chk("wnr_slots", n_log - base, 4);
    chk("wnr_d2", din_log[base+2], 8'h33);
    chk("wnr_c3", cmd_log[base+3], 3'b011);
    chk("wnr_err", r_err, 2'b10);
    chk("wnr_rdata", r_data, 8'h00);

    nack_on = 3;
    rd_byte = 8'h77;
    base = n_log;
    run_req(1'b1, 7'h50, 8'h44, 8'h00);
    chk("rna_slots", n_log - base, 6 * attempts);
    chk("rna_d4", din_log[base+4], 8'hA1);
    chk("rna_c5", cmd_log[base+5], 3'b011);
    seen = 0;
    for (int i = base; i < n_log; i++)
      if (cmd_log[i] == 3'b010) seen = 1;
    chk("rna_no_rd", seen, 0);
    chk("rna_err", r_err, 2'b01);
    chk("rna_rdata", r_data, 8'h00);

    nack_on = 1;
    base = n_log;
    run_req(1'b0, 7'h2A, 8'h01, 8'h02);
    chk("rty_slots", n_log - base, 3 * attempts);
    for (int a = 0; a < attempts; a++) begin
      chk("rty_start", cmd_log[base+3*a], 3'b000);
      chk("rty_addr", din_log[base+3*a+1], 8'h54);
      chk("rty_stop", cmd_log[base+3*a+2], 3'b011);
    end
    chk("rty_err", r_err, 2'b01);

    nack_on = 0;
    base = n_log;
    nr = n_rsp;
    @(negedge clk);
    req_valid = 1'b1;
    req_rw    = 1'b0;
    req_dev   = 7'h50;
    req_reg   = 8'h11;
    req_wdata = 8'h77;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (n_log - base >= 4) seen = 1;
    end
    chk("mid_reach_step3", seen, 1);
    chk("mid_busy", busy, 1);
    req_valid = 1'b1;
    req_dev   = 7'h0F;
    repeat (2) @(negedge clk);
    req_valid = 1'b0;
    chk("mid_no_extra", n_log - base, 4);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_wr", i2c_wr, 0);
    chk("mid_rst_cmd", i2c_cmd, 0);
    chk("mid_rst_din", i2c_din, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    nl = n_log;
    repeat (30) @(negedge clk);
    chk("post_rst_no_stop", n_log - nl, 0);
    chk("post_rst_no_rsp", n_rsp - nr, 0);
    chk("post_rst_idle", req_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
